// File: rtl/ula_multiciclo.sv
// EX-stage ALU: combinational single-cycle ops plus an iterative multiply/divide unit with HI/LO.
// Define ULA_OVERFLOW_EN to add the signed ADD/SUB overflow output.
module ula_multiciclo #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       OP,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ULA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nx;
  logic [SHW-1:0]   cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q, b_mag, dvd;
  logic             is_div, neg_q, neg_r, div0;

  logic [WIDTH-1:0] sum_w, diff_w;
  assign sum_w  = in1 + in2;
  assign diff_w = in1 - in2;

  // ---------------- single-cycle ops ----------------
  always_comb begin
    result = '0;
    case (OP)
      5'b00000: result = in1 & in2;
      5'b00001: result = in1 | in2;
      5'b00010: result = sum_w;
      5'b00011: result = in1 << in2[SHW-1:0];
      5'b00100: result = in1 >> in2[SHW-1:0];
      5'b00101: result = WIDTH'($signed(in1) >>> in2[SHW-1:0]);
      5'b00110: result = diff_w;
      5'b00111: result = WIDTH'($signed(in1) < $signed(in2));
      5'b01000: result = diff_w;
      5'b01001: result = in1 << shamt;
      5'b01010: result = in1 >> shamt;
      5'b01011: result = in1 ^ in2;
      5'b01100: result = ~(in1 | in2);
      5'b01101: result = WIDTH'($signed(in1) >>> shamt);
      5'b01111: result = WIDTH'(in1 < in2);
      5'b10100: result = hi;
      5'b10101: result = lo;
      default:  result = '0;
    endcase
  end

  // BNE-SUB inverts the sense so the branch is taken on inequality
  assign zero_flag = (OP == 5'b01000) ? (result != '0) : (result == '0);

`ifdef ULA_OVERFLOW_EN
  always_comb begin
    overflow = 1'b0;
    if (OP == 5'b00010)
      overflow = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_w[WIDTH-1] != in1[WIDTH-1]);
    else if (OP == 5'b00110)
      overflow = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_w[WIDTH-1] != in1[WIDTH-1]);
  end
`endif

  // ---------------- multi-cycle unit ----------------
  logic             accept, last;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign accept   = (state == IDLE) && start && (OP[4:2] == 3'b100);
  assign last     = (state == RUN) && (cnt == SHW'(WIDTH-1));
  assign sgn      = ~OP[0];
  assign a_neg    = sgn & in1[WIDTH-1];
  assign b_neg    = sgn & in2[WIDTH-1];
  assign a_mag_in = a_neg ? -in1 : in1;
  assign b_mag_in = b_neg ? -in2 : in2;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff, acc_n;
  logic [WIDTH-1:0] q_n;

  // one iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum  = acc + {1'b0, (q[0] ? b_mag : '0)};
    div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_mag};
    acc_n    = {1'b0, mul_sum[WIDTH:1]};
    q_n      = {mul_sum[0], q[WIDTH-1:1]};
    if (is_div) begin
      if (div_sh >= {1'b0, b_mag}) begin
        acc_n = div_diff;
        q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = div_sh;
        q_n   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, rem, hi_fin, lo_fin;

  // sign correction applied to the result of the final iteration
  always_comb begin
    prod   = {acc_n[WIDTH-1:0], q_n};
    prod_s = neg_q ? -prod : prod;
    quot   = neg_q ? -q_n : q_n;
    rem    = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    hi_fin = prod_s[2*WIDTH-1:WIDTH];
    lo_fin = prod_s[WIDTH-1:0];
    if (is_div) begin
      hi_fin = div0 ? dvd : rem;
      lo_fin = div0 ? '1  : quot;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      b_mag  <= '0;
      dvd    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      q      <= a_mag_in;
      b_mag  <= b_mag_in;
      dvd    <= in1;
      is_div <= OP[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0   <= (in2 == '0);
    end else if (state == RUN) begin
      cnt <= cnt + SHW'(1);
      acc <= acc_n;
      q   <= q_n;
      if (last) begin
        hi <= hi_fin;
        lo <= lo_fin;
      end
    end
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised successor of the datapath ALU: WIDTH-bit single-cycle arithmetic/logic ops plus an iterative multiply/divide unit with HI/LO registers.
- Sits in the EX stage. Control supplies a 5-bit OP. Single-cycle ops are combinational. Multi-cycle ops use a start/busy/done handshake, and the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in1  input  WIDTH  operand 1 (rs).
- in2  input  WIDTH  operand 2 (rt/immediate).
- OP  input  5  operation code.
- shamt  input  SHW  immediate shift amount.
- start  input  1  launch multi-cycle op (OP 10000..10011).
- result  output  WIDTH  combinational result.
- zero_flag  output  1  branch flag.
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi  output  WIDTH  HI register (remainder / upper product).
- lo  output  WIDTH  LO register (quotient / lower product).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - Reset: busy=0, done=0, hi=0, lo=0, FSM=IDLE.
  - result and zero_flag are combinational and carry no reset value.
- Single-cycle ops, OP[4]=0, zero latency:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 SLLV, 00100 SRLV, 00101 SRAV.
  - 00110 SUB, 00111 SLT (signed), 01000 BNE-SUB, 01001 SLL, 01010 SRL.
  - 01011 XOR, 01100 NOR, 01101 SRA, 01111 SLTU.
  - Variable shifts use in2[SHW-1:0] only. Immediate shifts use shamt.
  - ADD/SUB wrap modulo 2^WIDTH.
- Register-read ops: 10100 MFHI gives result=hi; 10101 MFLO gives result=lo.
- All other codes give result=0.
- zero_flag:
  - For OP 01000: zero_flag = (result != 0).
  - For every other OP: zero_flag = (result == 0).
- Multi-cycle ops: 10000 MULT (signed), 10001 MULTU, 10010 DIV (signed), 10011 DIVU.
  - During a multi-cycle op, result = 0.
- FSM states:
  - IDLE -> RUN: when start=1 and OP is multi-cycle. Operands are latched on this edge; busy=1 from the next cycle.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for exactly WIDTH cycles.
  - RUN -> FIN: after WIDTH iterations. Signs are corrected, hi/lo are written, done=1 for one cycle, busy=0.
  - FIN -> IDLE: unconditional, next cycle.
- Latency: start accepted at edge N; hi/lo valid and done=1 in cycle N+WIDTH+1.
- Handshake:
  - start while busy=1, or while in FIN, is ignored.
  - start with a non-multi-cycle OP is ignored.
  - Operands and OP may change freely after acceptance.
- Signed arithmetic:
  - Iterate on magnitudes, then apply the sign afterwards.
  - DIV quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
- Divide by zero:
  - Same latency as a normal divide.
  - lo = all ones; hi = dividend.
- Signed overflow, DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1), hi = 0.
- MFHI/MFLO while busy: return the old hi/lo values. Control must stall on busy.
- Reset while busy: aborts the op in the same edge. hi/lo = 0, no done pulse.

Optional Feature:
- Macro: ULA_OVERFLOW_EN.
- When defined:
  - Adds output port overflow, 1 bit, combinational.
  - For OP 00010: overflow=1 on signed overflow of the ADD.
  - For OP 00110: overflow=1 on signed overflow of the SUB.
  - For all other ops: overflow=0.
  - The result value is unchanged.
- When undefined: port absent, no logic generated.

Test Plan:
- WIDTH=32, OP=00111, in1=0xFFFFFFFF, in2=1 -> result=1. Then OP=01111 -> result=0. OP=01000, in1=in2=5 -> zero_flag=0.
- OP=10000, in1=-7, in2=3, start pulse -> busy=1 for 32 cycles, done in cycle N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then OP=10101 -> result=0xFFFFFFEB.
- OP=10010, in1=-7, in2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). OP=10011, in1=100, in2=0 -> lo=0xFFFFFFFF, hi=100.
- MULTU 0xFFFFFFFF*0xFFFFFFFF; second start at cycle N+5 with different operands -> ignored; hi=0xFFFFFFFE, lo=0x00000001.
- DIV running, assert reset at cycle N+10 -> next cycle busy=0, hi=lo=0, no done pulse. New start then completes normally.
- WIDTH=16 with ULA_OVERFLOW_EN: OP=00010, 0x7FFF+1 -> result=0x8000, overflow=1. OP=01001, shamt=15, in1=1 -> result=0x8000, overflow=0.
